// File: rtl/mips_data_mem.sv
// Byte-addressable big-endian data memory for the single-cycle MIPS datapath.
// Combinational loads, edge-committed stores, sticky capture of the first misaligned access.
module mips_data_mem #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        fault,
    output logic [31:0] fault_addr
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] word_idx;
    logic [31:0]   cur_word;
    logic [31:0]   merged_word;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    size_e         sz;

    // Upper address bits above the array are dropped, so accesses wrap.
    assign word_idx = addr[AW+1:2];
    assign cur_word = mem[word_idx];
    assign sz       = size_e'(size);

    assign misaligned = (mem_read | mem_write) &
                        ((sz == SZ_ILLEGAL) |
                         ((sz == SZ_HALF) & addr[0]) |
                         ((sz == SZ_WORD) & (addr[1:0] != 2'b00)));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ld_byte = cur_word[31:24];
        unique case (addr[1:0])
            2'd0: ld_byte = cur_word[31:24];
            2'd1: ld_byte = cur_word[23:16];
            2'd2: ld_byte = cur_word[15:8];
            2'd3: ld_byte = cur_word[7:0];
        endcase
        ld_half = addr[1] ? cur_word[15:0] : cur_word[31:16];

        rdata = '0;
        if (mem_read && !misaligned) begin
            unique case (sz)
                SZ_BYTE: rdata = unsigned_ld ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
                SZ_HALF: rdata = unsigned_ld ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
                SZ_WORD: rdata = cur_word;
                default: rdata = '0;
            endcase
        end
    end

    // Merge store data into the existing word; untouched lanes keep their contents.
    always_comb begin
        merged_word = cur_word;
        unique case (sz)
            SZ_BYTE: begin
                unique case (addr[1:0])
                    2'd0: merged_word[31:24] = wdata[7:0];
                    2'd1: merged_word[23:16] = wdata[7:0];
                    2'd2: merged_word[15:8]  = wdata[7:0];
                    2'd3: merged_word[7:0]   = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (addr[1]) merged_word[15:0]  = wdata[15:0];
                else         merged_word[31:16] = wdata[15:0];
            end
            SZ_WORD: merged_word = wdata;
            default: merged_word = cur_word;
        endcase
    end

    // NOTE: the array is cleared by reset, so it maps to flops rather than a RAM macro;
    // that is the price of a one-edge full clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
            fault      <= 1'b0;
            fault_addr <= '0;
        end else begin
            if (mem_write && !misaligned) begin
                mem[word_idx] <= merged_word;
            end
            if (misaligned && !fault) begin
                fault      <= 1'b1;
                fault_addr <= addr;
            end
        end
    end
endmodule

// File: tb/tb_mips_data_mem.sv
// Self-checking bench for mips_data_mem: expected values queued at stimulus time,
// popped and compared when the combinational/registered outputs are sampled.
module tb_mips_data_mem;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] rdata;
    logic        misaligned;
    logic        fault;
    logic [31:0] fault_addr;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q [$];

    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

    always #5 clk = ~clk;

    mips_data_mem #(.DEPTH_WORDS(256)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .mem_read(mem_read), .mem_write(mem_write), .size(size),
        .unsigned_ld(unsigned_ld), .rdata(rdata), .misaligned(misaligned),
        .fault(fault), .fault_addr(fault_addr)
    );

    // Apply one access on the falling edge; any store commits at the following rising edge.
    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_read = rd; mem_write = wr; size = sz; unsigned_ld = uns; addr = a; wdata = d;
    endtask

    task automatic test_reset();
        logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'h3FC};
        logic [31:0] e;
        reset = 1'b1;
        drive(0, 0, W, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        foreach (addrs[i]) begin
            drive(1, 0, W, 0, addrs[i], 0);
            exp_q.push_back(32'h0);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (rdata !== e) begin
                failures++;
                $display("FAIL reset_lw_%0h: rdata=%h expected=%h", addrs[i], rdata, e);
            end
        end
        checks++;
        if (fault !== 1'b0 || fault_addr !== 32'h0 || misaligned !== 1'b0) begin
            failures++;
            $display("FAIL reset_fault: fault=%b fault_addr=%h misaligned=%b expected 0/0/0",
                     fault, fault_addr, misaligned);
        end
    endtask

    task automatic test_word_bytes();
        logic [31:0] la [4] = '{32'h10, 32'h13, 32'h12, 32'h10};
        logic [1:0]  ls [4] = '{B, B, H, W};
        logic [31:0] le [4] = '{32'h00000011, 32'h00000044, 32'h00003344, 32'h11223344};
        logic [31:0] e;
        drive(0, 1, W, 0, 32'h10, 32'h11223344);
        foreach (la[i]) begin
            drive(1, 0, ls[i], 0, la[i], 32'hFFFF_FFFF);
            exp_q.push_back(le[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (rdata !== e) begin
                failures++;
                $display("FAIL lanes_%0d: rdata=%h expected=%h", i, rdata, e);
            end
        end
    endtask

    task automatic test_sb_sh();
        logic [31:0] la [3] = '{32'h20, 32'h21, 32'h21};
        logic [1:0]  ls [3] = '{W, B, B};
        logic        lu [3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] le [3] = '{32'h00AA0000, 32'hFFFFFFAA, 32'h000000AA};
        logic [31:0] ha [3] = '{32'h22, 32'h22, 32'h20};
        logic [1:0]  hs [3] = '{H, H, W};
        logic        hu [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] he [3] = '{32'hFFFF8001, 32'h00008001, 32'h00AA8001};
        logic [31:0] e;
        drive(0, 1, B, 0, 32'h21, 32'h123456AA);
        foreach (la[i]) begin
            drive(1, 0, ls[i], lu[i], la[i], 0);
            exp_q.push_back(le[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (rdata !== e) begin
                failures++;
                $display("FAIL sb_%0d: rdata=%h expected=%h", i, rdata, e);
            end
        end
        drive(0, 1, H, 0, 32'h22, 32'hFFFF8001);
        foreach (ha[i]) begin
            drive(1, 0, hs[i], hu[i], ha[i], 0);
            exp_q.push_back(he[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (rdata !== e) begin
                failures++;
                $display("FAIL sh_%0d: rdata=%h expected=%h", i, rdata, e);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] e;
        drive(0, 1, W, 0, 32'h40, 32'hCAFEF00D);
        drive(0, 1, W, 0, 32'h41, 32'h12345678);
        #1;
        checks++;
        if (misaligned !== 1'b1 || fault !== 1'b0) begin
            failures++;
            $display("FAIL sw_misaligned: misaligned=%b fault=%b expected 1/0", misaligned, fault);
        end
        drive(1, 0, H, 0, 32'h43, 0);
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (fault !== 1'b1 || fault_addr !== 32'h41) begin
            failures++;
            $display("FAIL fault_capture: fault=%b fault_addr=%h expected 1/00000041", fault, fault_addr);
        end
        checks++;
        if (rdata !== e || misaligned !== 1'b1) begin
            failures++;
            $display("FAIL lh_misaligned: rdata=%h misaligned=%b expected %h/1", rdata, misaligned, e);
        end
        drive(1, 0, X, 0, 32'h44, 0);
        #1;
        checks++;
        if (misaligned !== 1'b1 || rdata !== 32'h0 || fault_addr !== 32'h41) begin
            failures++;
            $display("FAIL size_illegal: misaligned=%b rdata=%h fault_addr=%h expected 1/0/00000041",
                     misaligned, rdata, fault_addr);
        end
        drive(0, 0, X, 0, 32'h45, 0);
        #1;
        checks++;
        if (misaligned !== 1'b0) begin
            failures++;
            $display("FAIL idle_not_misaligned: misaligned=%b expected 0", misaligned);
        end
        drive(1, 0, W, 0, 32'h40, 0);
        exp_q.push_back(32'hCAFEF00D);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (rdata !== e || misaligned !== 1'b0 || fault_addr !== 32'h41) begin
            failures++;
            $display("FAIL no_misaligned_write: rdata=%h misaligned=%b fault_addr=%h expected %h/0/00000041",
                     rdata, misaligned, fault_addr, e);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        drive(0, 1, W, 0, 32'h400, 32'hDEADBEEF);
        drive(1, 0, W, 0, 32'h000, 0);
        exp_q.push_back(32'hDEADBEEF);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (rdata !== e) begin
            failures++;
            $display("FAIL wrap: rdata=%h expected=%h", rdata, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        drive(1, 1, W, 0, 32'h10, 32'h55667788);
        exp_q.push_back(32'h11223344);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (rdata !== e) begin
            failures++;
            $display("FAIL rw_old_value: rdata=%h expected=%h", rdata, e);
        end
        drive(1, 0, W, 0, 32'h10, 0);
        exp_q.push_back(32'h55667788);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (rdata !== e) begin
            failures++;
            $display("FAIL rw_new_value: rdata=%h expected=%h", rdata, e);
        end
    endtask

    task automatic test_reset_store();
        logic [31:0] e;
        drive(0, 1, W, 0, 32'h10, 32'h99999999);
        reset = 1'b1;
        drive(1, 0, W, 0, 32'h10, 0);
        reset = 1'b0;
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (rdata !== e) begin
            failures++;
            $display("FAIL reset_store: rdata=%h expected=%h", rdata, e);
        end
        checks++;
        if (fault !== 1'b0 || fault_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_clears_fault: fault=%b fault_addr=%h expected 0/0", fault, fault_addr);
        end
        drive(1, 0, W, 0, 32'h20, 0);
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (rdata !== e) begin
            failures++;
            $display("FAIL reset_clears_array: rdata=%h expected=%h", rdata, e);
        end
    endtask

    initial begin
        reset = 1'b1; addr = '0; wdata = '0; mem_read = 1'b0; mem_write = 1'b0;
        size = W; unsigned_ld = 1'b0;
        test_reset();
        test_word_bytes();
        test_sb_sh();
        test_misaligned();
        test_wrap();
        test_back_to_back();
        test_reset_store();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
